esm_dep_tracker: RTL and testbench
==================================

ESM_DEP_TRACKER -- requirements
Module: esm_dep_tracker

Interface
REQ-001 SHALL provide parameter IW, default 32, instruction word width.
REQ-002 SHALL provide parameter BS, default 16, buffer slots (power of two, >=4).
REQ-003 SHALL provide parameter REGNUM, default 32, architectural registers; register address width RA = $clog2(REGNUM).
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 ins_valid  input  1  insert instruction this cycle.
REQ-007 ins_index  input  $clog2(BS)  target slot of insert.
REQ-008 ins_instr  input  IW  instruction; rd=[11:7], rs1=[19:15], rs2=[24:20], truncated to RA bits.
REQ-009 ins_regwrite  input  1  rd is written; else rd treated as x0.
REQ-010 ins_alusrc  input  1  1 = immediate operand; rs2 treated as x0.
REQ-011 cmp_valid  input  1  completion of slot cmp_index this cycle.
REQ-012 cmp_index  input  $clog2(BS)  completing slot.
REQ-013 flush  input  1  synchronous clear of all tracking state.
REQ-014 independent_instr  output  [0:BS-1]  bit i = slot i valid with zero outstanding dependencies.
REQ-015 occupancy  output  $clog2(BS)+1  count of valid slots.
REQ-016 err  output  1  sticky protocol-error flag.

Function
REQ-017 SHALL keep per slot: valid bit and dependency row dep[i][0:BS-1]; per register: producer slot plus producer-valid bit.
REQ-018 On insert SHALL set dep[ins_index][j] for each j that is valid producer of nonzero rs1 or nonzero rs2 (RAW).
REQ-019 Register x0 SHALL never create a dependency nor be recorded as producer.
REQ-020 On insert with ins_regwrite and rd!=0 SHALL record producer[rd]=ins_index, valid.
REQ-021 On completion SHALL clear valid[cmp_index], clear column cmp_index in every row, clear the slot's own row, and invalidate every producer entry equal to cmp_index.
REQ-022 Insert and completion in the same cycle SHALL bypass: no dependency bit set on the completing slot; completion producer-invalidate SHALL not cancel a same-cycle producer write from the insert.
REQ-023 Same-cycle insert and completion of the same slot SHALL be treated as completion then insert (slot ends valid with new row).
REQ-024 independent_instr SHALL be a combinational function of registered state only: valid[i] AND ~|dep[i]; an insert becomes visible the cycle after its clock edge.
REQ-025 occupancy SHALL count +1 per insert, -1 per completion, unchanged when both occur, never wrap.
REQ-026 Insert to an already-valid slot (not completing that cycle) SHALL set err, overwrite the slot, not double-count occupancy.
REQ-027 Completion of an invalid slot SHALL set err and otherwise be ignored.
REQ-028 flush SHALL clear all valid, dep and producer state and occupancy in one cycle, has priority over insert/completion, and SHALL not clear err.

Reset
REQ-029 While rst low: all valid, dep, producer bits 0, occupancy 0, err 0, independent_instr all 0.
REQ-030 Reset asserted mid-operation SHALL discard all state immediately (asynchronous); first insert accepted on first rising edge after rst deasserts.

Configuration
REQ-031 Macro ESM_WAW_TRACK_EN defined: insert with ins_regwrite and rd!=0 additionally depends on the valid producer of rd (WAW), subject to REQ-022 bypass.
REQ-032 ESM_WAW_TRACK_EN undefined: only RAW dependencies on rs1/rs2 SHALL be tracked; rd never creates a dependency.

Verification
REQ-033 Reset then insert slot 0 "add x5,x1,x2" -> next cycle independent_instr[0]=1, occupancy=1, err=0.
REQ-034 Insert slot 0 writing x5, then slot 1 reading x5 -> bit1=0; complete slot 0 -> next cycle bit1=1, occupancy=1.
REQ-035 Slot 0 writes x5 valid; same cycle complete slot 0 and insert slot 2 reading x5 -> bit2=1 next cycle, dep[2] all zero.
REQ-036 Insert slot 3 twice without completion -> err=1 and stays 1 through flush; occupancy=1.
REQ-037 Slot 0 writes x7; insert slot 1 writing x7 (alusrc=1, rs1=x0) -> bit1=1 without ESM_WAW_TRACK_EN, bit1=0 with it.
REQ-038 Fill all BS slots, assert rst low mid-cycle -> independent_instr=0, occupancy=0 before next clock edge.

Source files
------------

// File: rtl/esm_dep_tracker.sv
// esm_dep_tracker: RAW (optionally WAW) dependency scoreboard for an
// out-of-order instruction buffer of BS slots.
//
// Configuration macro: ESM_WAW_TRACK_EN
//   defined   - an insert that writes rd also waits on the live producer of rd
//   undefined - only rs1/rs2 read-after-write dependencies are tracked
//
// Ports
//   clk, rst           clock, asynchronous active-low reset
//   ins_valid/index    insert an instruction into slot ins_index
//   ins_instr          instruction word (rd=[11:7] rs1=[19:15] rs2=[24:20])
//   ins_regwrite       rd is really written (otherwise rd behaves as x0)
//   ins_alusrc         immediate operand (rs2 behaves as x0)
//   cmp_valid/index    slot cmp_index retires this cycle
//   flush              synchronous clear of all tracking state (err kept)
//   independent_instr  bit i: slot i valid with no outstanding dependency
//   occupancy          number of valid slots
//   err                sticky protocol error (overwrite / bad completion)

// Per-slot state: valid bit plus dependency row.
module esm_dep_slot #(
    parameter int BS   = 16,
    parameter int SW   = 4,
    parameter int SLOT = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          cmp_ok,
    input  logic [SW-1:0] cmp_index,
    input  logic          ins_hit,
    input  logic [BS-1:0] new_row,
    output logic          valid,
    output logic [BS-1:0] row
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            row   <= '0;
        end else if (flush) begin
            valid <= 1'b0;
            row   <= '0;
        end else if (ins_hit) begin
            // Insert wins over a same-cycle completion of this slot: the
            // slot ends valid with the freshly built row.
            valid <= 1'b1;
            row   <= new_row;
        end else if (cmp_ok && cmp_index == SW'(SLOT)) begin
            valid <= 1'b0;
            row   <= '0;
        end else if (cmp_ok) begin
            row[cmp_index] <= 1'b0;
        end
    end
endmodule

module esm_dep_tracker #(
    parameter int IW     = 32,
    parameter int BS     = 16,
    parameter int REGNUM = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ins_valid,
    input  logic [$clog2(BS)-1:0] ins_index,
    input  logic [IW-1:0]        ins_instr,
    input  logic                 ins_regwrite,
    input  logic                 ins_alusrc,
    input  logic                 cmp_valid,
    input  logic [$clog2(BS)-1:0] cmp_index,
    input  logic                 flush,
    output logic [0:BS-1]        independent_instr,
    output logic [$clog2(BS):0]  occupancy,
    output logic                 err
);
    localparam int SW = $clog2(BS);
    localparam int RA = $clog2(REGNUM);
    localparam int OW = SW + 1;

    logic [BS-1:0]              valid;
    logic [BS-1:0][BS-1:0]      dep;
    logic [BS-1:0]              new_row;
    logic [REGNUM-1:0]          prod_vld;
    logic [REGNUM-1:0][SW-1:0]  prod_slot;

    logic [RA-1:0] rs1, rs2, rd;
    logic          cmp_ok, cmp_bad, same_slot, ins_over, occ_inc;

    // Only the register fields are consumed; the rest of the word is opaque.
    logic unused_instr;
    assign unused_instr = ^ins_instr;

    assign rs1 = ins_instr[15 +: RA];
    assign rs2 = ins_alusrc   ? '0 : ins_instr[20 +: RA];
    assign rd  = ins_regwrite ? ins_instr[7 +: RA] : '0;

    assign cmp_ok    = cmp_valid &  valid[cmp_index];
    assign cmp_bad   = cmp_valid & ~valid[cmp_index];
    assign same_slot = cmp_ok & (cmp_index == ins_index);
    // Overwriting a live slot is an error unless it retires this same cycle.
    assign ins_over  = ins_valid & valid[ins_index] & ~same_slot;
    assign occ_inc   = ins_valid & ~ins_over;

    // Row for the incoming instruction. A producer retiring this cycle is
    // bypassed, and a slot never waits on itself (covers overwrite).
    always_comb begin
        new_row = '0;
        for (int j = 0; j < BS; j++) begin
            new_row[j] =
                ((rs1 != '0) && prod_vld[rs1] && (prod_slot[rs1] == SW'(j))) ||
                ((rs2 != '0) && prod_vld[rs2] && (prod_slot[rs2] == SW'(j)))
`ifdef ESM_WAW_TRACK_EN
                || ((rd != '0) && prod_vld[rd] && (prod_slot[rd] == SW'(j)))
`endif
                ;
            if (cmp_ok && cmp_index == SW'(j)) new_row[j] = 1'b0;
            if (ins_index == SW'(j))           new_row[j] = 1'b0;
        end
    end

    for (genvar i = 0; i < BS; i++) begin : g_slot
        esm_dep_slot #(.BS(BS), .SW(SW), .SLOT(i)) u_slot (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush),
            .cmp_ok    (cmp_ok),
            .cmp_index (cmp_index),
            .ins_hit   (ins_valid && (ins_index == SW'(i))),
            .new_row   (new_row),
            .valid     (valid[i]),
            .row       (dep[i])
        );
        assign independent_instr[i] = valid[i] & ~|dep[i];
    end

    // Producer table. Entries naming a retiring slot, or the slot being
    // (re)filled, go stale; the insert's own rd write is applied last so a
    // same-cycle invalidate never cancels it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prod_vld  <= '0;
            prod_slot <= '0;
        end else if (flush) begin
            prod_vld  <= '0;
        end else begin
            for (int r = 0; r < REGNUM; r++) begin
                if ((cmp_ok && prod_slot[r] == cmp_index) ||
                    (ins_valid && prod_slot[r] == ins_index))
                    prod_vld[r] <= 1'b0;
            end
            if (ins_valid && rd != '0) begin
                prod_vld[rd]  <= 1'b1;
                prod_slot[rd] <= ins_index;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occupancy <= '0;
        end else if (flush) begin
            occupancy <= '0;
        end else if (occ_inc && !cmp_ok) begin
            occupancy <= occupancy + OW'(1);
        end else if (cmp_ok && !occ_inc) begin
            occupancy <= occupancy - OW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            err <= 1'b0;
        else if (!flush && (ins_over || cmp_bad))
            err <= 1'b1;
    end
endmodule

// File: tb/tb_esm_dep_tracker.sv
// Directed bench for esm_dep_tracker (default parameters).
module tb_esm_dep_tracker;
    localparam int IW = 32, BS = 16, REGNUM = 32, SW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ins_valid = 1'b0;
    logic [SW-1:0] ins_index = '0;
    logic [IW-1:0] ins_instr = '0;
    logic          ins_regwrite = 1'b0;
    logic          ins_alusrc = 1'b0;
    logic          cmp_valid = 1'b0;
    logic [SW-1:0] cmp_index = '0;
    logic          flush = 1'b0;
    logic [0:BS-1] independent_instr;
    logic [SW:0]   occupancy;
    logic          err;

    always #5 clk = ~clk;

    esm_dep_tracker #(.IW(IW), .BS(BS), .REGNUM(REGNUM)) dut (
        .clk               (clk),
        .rst               (rst),
        .ins_valid         (ins_valid),
        .ins_index         (ins_index),
        .ins_instr         (ins_instr),
        .ins_regwrite      (ins_regwrite),
        .ins_alusrc        (ins_alusrc),
        .cmp_valid         (cmp_valid),
        .cmp_index         (cmp_index),
        .flush             (flush),
        .independent_instr (independent_instr),
        .occupancy         (occupancy),
        .err               (err)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] mk(input int rd, input int rs1, input int rs2);
        return {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), 7'h33};
    endfunction

    // One clock of stimulus; outputs are sampled 1 time unit after the edge.
    task automatic cyc(input bit iv, input int ii, input logic [31:0] instr,
                       input bit rw, input bit as, input bit cv, input int ci,
                       input bit fl);
        ins_valid = iv; ins_index = SW'(ii); ins_instr = instr;
        ins_regwrite = rw; ins_alusrc = as;
        cmp_valid = cv; cmp_index = SW'(ci); flush = fl;
        @(posedge clk);
        #1;
        ins_valid = 1'b0; cmp_valid = 1'b0; flush = 1'b0;
        ins_regwrite = 1'b0; ins_alusrc = 1'b0;
    endtask

    task automatic ins(input int idx, input int rd, input int rs1, input int rs2,
                       input bit rw = 1'b1, input bit as = 1'b0);
        cyc(1'b1, idx, mk(rd, rs1, rs2), rw, as, 1'b0, 0, 1'b0);
    endtask

    task automatic cmp(input int idx);
        cyc(1'b0, 0, '0, 1'b0, 1'b0, 1'b1, idx, 1'b0);
    endtask

    bit waw_exp;

    initial begin
`ifdef ESM_WAW_TRACK_EN
        waw_exp = 1'b0;
`else
        waw_exp = 1'b1;
`endif
        #12;
        chk("rst_indep", 32'(independent_instr), 32'h0);
        chk("rst_occ",   32'(occupancy), 32'd0);
        chk("rst_err",   32'(err), 32'd0);
        rst = 1'b1;

        // add x5,x1,x2 into slot 0
        ins(0, 5, 1, 2);
        chk("add_indep0", 32'(independent_instr[0]), 32'd1);
        chk("add_occ",    32'(occupancy), 32'd1);
        chk("add_err",    32'(err), 32'd0);

        // RAW on x5, released by completion
        ins(1, 6, 5, 0);
        chk("raw_indep1", 32'(independent_instr[1]), 32'd0);
        chk("raw_occ",    32'(occupancy), 32'd2);
        cmp(0);
        chk("rel_indep1", 32'(independent_instr[1]), 32'd1);
        chk("rel_indep0", 32'(independent_instr[0]), 32'd0);
        chk("rel_occ",    32'(occupancy), 32'd1);
        cmp(1);
        chk("empty_occ",  32'(occupancy), 32'd0);

        // Bypass: producer retires in the same cycle the reader inserts
        ins(0, 5, 1, 2);
        cyc(1'b1, 2, mk(8, 5, 0), 1'b1, 1'b0, 1'b1, 0, 1'b0);
        chk("byp_indep2", 32'(independent_instr[2]), 32'd1);
        chk("byp_occ",    32'(occupancy), 32'd1);
        chk("byp_err",    32'(err), 32'd0);
        cmp(2);

        // Complete and re-insert the same slot; new producer write survives
        ins(0, 9, 1, 2);
        cyc(1'b1, 0, mk(9, 9, 0), 1'b1, 1'b0, 1'b1, 0, 1'b0);
        chk("same_indep0", 32'(independent_instr[0]), 32'd1);
        chk("same_occ",    32'(occupancy), 32'd1);
        ins(1, 10, 9, 0);
        chk("same_prod",   32'(independent_instr[1]), 32'd0);
        cmp(0);
        chk("same_rel",    32'(independent_instr[1]), 32'd1);
        cmp(1);

        // WAW on x7 with immediate operand (rs2 field x7 must be ignored)
        ins(0, 7, 1, 2);
        ins(1, 7, 0, 7, 1'b1, 1'b1);
        chk("waw_indep1", 32'(independent_instr[1]), 32'(waw_exp));
        cmp(0);
        chk("waw_rel",    32'(independent_instr[1]), 32'd1);
        cmp(1);

        // rd without regwrite records no producer
        ins(4, 10, 1, 2, 1'b0);
        ins(5, 12, 10, 0);
        chk("norw_indep5", 32'(independent_instr[5]), 32'd1);
        chk("norw_occ",    32'(occupancy), 32'd2);

        // Flush beats a simultaneous insert
        cyc(1'b1, 6, mk(1, 0, 0), 1'b1, 1'b0, 1'b0, 0, 1'b1);
        chk("fl_occ",   32'(occupancy), 32'd0);
        chk("fl_indep", 32'(independent_instr), 32'h0);
        chk("fl_err",   32'(err), 32'd0);

        // Double insert into slot 3
        ins(3, 0, 0, 0, 1'b0);
        ins(3, 0, 0, 0, 1'b0);
        chk("dbl_err", 32'(err), 32'd1);
        chk("dbl_occ", 32'(occupancy), 32'd1);
        cyc(1'b0, 0, '0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        chk("dbl_fl_err", 32'(err), 32'd1);
        chk("dbl_fl_occ", 32'(occupancy), 32'd0);

        // Fill all slots, then async reset between edges
        for (int i = 0; i < BS; i++) ins(i, 0, 0, 0, 1'b0);
        chk("full_occ",   32'(occupancy), 32'd16);
        chk("full_indep", 32'(independent_instr), 32'hFFFF);
        #2 rst = 1'b0;
        #1;
        chk("arst_indep", 32'(independent_instr), 32'h0);
        chk("arst_occ",   32'(occupancy), 32'd0);
        chk("arst_err",   32'(err), 32'd0);
        #2 rst = 1'b1;
        ins(0, 5, 1, 2);
        chk("post_occ",    32'(occupancy), 32'd1);
        chk("post_indep0", 32'(independent_instr[0]), 32'd1);

        // Completion of an invalid slot
        cmp(7);
        chk("badcmp_err", 32'(err), 32'd1);
        chk("badcmp_occ", 32'(occupancy), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
